ddr_cmd_scheduler: RTL

Closed-page DDR5 command sequencer in the DIMM clock domain. Accepts one decoded memory request at a time from the 16-entry request queue and issues the ACT0/ACT1, RD0/RD1 or WR0/WR1, and PRE command stream with tRCD, tCL, tBURST and same-bank tRP spacing enforced. Reports completion back to the queue owner.

---
 rtl/ddr_cmd_scheduler_if.sv | 31 +++
 rtl/ddr_cmd_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_scheduler_if.sv
// Request/command/completion bundle between the request queue and the
// DDR5 command scheduler. The queue owner is the master; the scheduler is the slave.
interface ddr_cmd_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [33:0] req_addr;
    logic [3:0]  req_core;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        cmd_ch;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_addr;
    logic        data_phase;
    logic        done;
    logic [3:0]  done_core;
    logic        done_err;

    modport master (
        output req_valid, req_op, req_addr, req_core,
        input  req_ready, cmd_valid, cmd, cmd_ch, cmd_bg, cmd_ba, cmd_addr,
               data_phase, done, done_core, done_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_core,
        output req_ready, cmd_valid, cmd, cmd_ch, cmd_bg, cmd_ba, cmd_addr,
               data_phase, done, done_core, done_err
    );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// Closed-page DDR5 command sequencer: one request at a time, issues
// ACT0/ACT1, RD/WR pair, PRE with tRCD/tCL/tBURST spacing and same-bank tRP.
// All command outputs decode from registered state and latched request fields.
module ddr_cmd_scheduler #(
    parameter int TRCD   = 39,
    parameter int TCL    = 40,
    parameter int TBURST = 8,
    parameter int TRP    = 39
) (
    input  logic               dimm_clk,
    input  logic               rst,
    ddr_cmd_scheduler_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_TRP_WAIT, S_ACT0, S_ACT1, S_RCD_WAIT,
        S_CAS0, S_CAS1, S_DATA_WAIT, S_PRE, S_ERR
    } state_t;

    // Wait-state counters count down to 0; each wait state lasts LOAD+1 cycles.
    // RCD_LOAD is unused when TRCD==2 (ACT1 goes straight to CAS0).
    localparam logic [9:0] RCD_LOAD  = 10'(TRCD - 3);
    localparam logic [9:0] DATA_LOAD = 10'(TCL + TBURST - 3);
    localparam logic [9:0] BURST_LEN = 10'(TBURST);
    localparam logic [7:0] TRP_LOAD  = 8'(TRP - 1);

    state_t      r_state, w_next;
    logic [9:0]  r_cnt, w_cnt_val;
    logic        w_cnt_load;
    logic [1:0]  r_op;
    logic        r_ch;
    logic [2:0]  r_bg;
    logic [1:0]  r_ba;
    logic [15:0] r_row;
    logic [5:0]  r_col;
    logic [3:0]  r_core;
    logic [7:0]  r_trp;
    logic [4:0]  r_last_bank;
    logic        r_last_vld;
    logic        w_accept;
    logic        w_same_bank;
    logic        w_unused;

    // col_lo and byte fields have no meaning for the command stream
    assign w_unused = &{1'b0, bus.req_addr[5:0]};

    assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
    assign w_same_bank = r_last_vld && (r_last_bank == {bus.req_addr[9:7], bus.req_addr[11:10]});
    assign bus.req_ready = (r_state == S_IDLE) && !rst;

    // Next-state and wait-counter load decisions
    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == 2'd3)                 w_next = S_ERR;
                    else if (w_same_bank && r_trp != 8'd0)  w_next = S_TRP_WAIT;
                    else                                    w_next = S_ACT0;
                end
            end
            // Leave when the counter hits 0 on this same edge
            S_TRP_WAIT: if (r_trp <= 8'd1) w_next = S_ACT0;
            S_ACT0:     w_next = S_ACT1;
            S_ACT1: begin
                if (TRCD > 2) begin
                    w_next     = S_RCD_WAIT;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = RCD_LOAD;
                end else begin
                    w_next = S_CAS0;
                end
            end
            S_RCD_WAIT: if (r_cnt == 10'd0) w_next = S_CAS0;
            S_CAS0:     w_next = S_CAS1;
            S_CAS1: begin
                w_next     = S_DATA_WAIT;
                w_cnt_load = 1'b1;
                w_cnt_val  = DATA_LOAD;
            end
            S_DATA_WAIT: if (r_cnt == 10'd0) w_next = S_PRE;
            S_PRE:       w_next = S_IDLE;
            S_ERR:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // State register and shared wait counter
    always_ff @(posedge dimm_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cnt_load)          r_cnt <= w_cnt_val;
            else if (r_cnt != 10'd0) r_cnt <= r_cnt - 10'd1;
        end
    end

    // Capture the request fields on acceptance
    always_ff @(posedge dimm_clk) begin
        if (rst) begin
            r_op <= '0; r_ch <= 1'b0; r_bg <= '0; r_ba <= '0;
            r_row <= '0; r_col <= '0; r_core <= '0;
        end else if (w_accept) begin
            r_op   <= bus.req_op;
            r_row  <= bus.req_addr[33:18];
            r_col  <= bus.req_addr[17:12];
            r_ba   <= bus.req_addr[11:10];
            r_bg   <= bus.req_addr[9:7];
            r_ch   <= bus.req_addr[6];
            r_core <= bus.req_core;
        end
    end

    // Same-bank precharge tracker: remembers the last PRE'd bank and its remaining tRP
    always_ff @(posedge dimm_clk) begin
        if (rst) begin
            r_trp       <= '0;
            r_last_bank <= '0;
            r_last_vld  <= 1'b0;
        end else if (r_state == S_PRE) begin
            r_trp       <= TRP_LOAD;
            r_last_bank <= {r_bg, r_ba};
            r_last_vld  <= 1'b1;
        end else if (r_trp != 8'd0) begin
            r_trp <= r_trp - 8'd1;
        end
    end

    // Command/completion outputs decoded from the registered state
    always_comb begin
        bus.cmd_valid  = 1'b0;
        bus.cmd        = 3'd0;
        bus.cmd_ch     = 1'b0;
        bus.cmd_bg     = 3'd0;
        bus.cmd_ba     = 2'd0;
        bus.cmd_addr   = 16'd0;
        bus.data_phase = 1'b0;
        bus.done       = 1'b0;
        bus.done_core  = 4'd0;
        bus.done_err   = 1'b0;
        case (r_state)
            S_ACT0, S_ACT1: begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = (r_state == S_ACT0) ? 3'd1 : 3'd2;
                bus.cmd_ch    = r_ch;
                bus.cmd_bg    = r_bg;
                bus.cmd_ba    = r_ba;
                bus.cmd_addr  = r_row;
            end
            S_CAS0, S_CAS1: begin
                bus.cmd_valid = 1'b1;
                if (r_op == 2'd1) bus.cmd = (r_state == S_CAS0) ? 3'd5 : 3'd6;
                else              bus.cmd = (r_state == S_CAS0) ? 3'd3 : 3'd4;
                bus.cmd_ch    = r_ch;
                bus.cmd_bg    = r_bg;
                bus.cmd_ba    = r_ba;
                bus.cmd_addr  = {10'b0, r_col};
            end
            // Data beats are the last TBURST cycles of the wait
            S_DATA_WAIT: bus.data_phase = (r_cnt < BURST_LEN);
            S_PRE: begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = 3'd7;
                bus.cmd_ch    = r_ch;
                bus.cmd_bg    = r_bg;
                bus.cmd_ba    = r_ba;
                bus.done      = 1'b1;
                bus.done_core = r_core;
            end
            S_ERR: begin
                bus.done      = 1'b1;
                bus.done_core = r_core;
                bus.done_err  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
